rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 SHALL have parameter RS_ALU_SIZE, default 8, number of entries.
REQ-002 SHALL have parameter RS_ALU_LEN, default 3, entry index width, equal to log2(RS_ALU_SIZE).
REQ-003 SHALL have ports as follows. Reset is reset, synchronous, active-high. Clock is clock.
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- commit_mis_pred  in  1  flush all entries
- rs_alu_enable  in  1  dispatch request this cycle
- opa_ready, opb_ready  in  1 each  operand value valid at dispatch
- opa_value, opb_value  in  `XLEN each  operand value (meaningful when ready)
- opa_preg_idx, opb_preg_idx  in  `PRF_LEN each  operand tag
- dest_preg_idx  in  `PRF_LEN  destination physical register
- rob_idx  in  `ROB_LEN  ROB entry
- PC  in  `XLEN  instruction PC
- alu_func  in  ALU_FUNC  operation
- cdb_broadcast_valid  in  1  CDB result valid
- cdb_dest_preg_idx  in  `PRF_LEN  CDB tag
- cdb_broadcast_value  in  `XLEN  CDB value
- alu_ready  in  1  ALU accepts an issue this cycle
- rs_alu_full  out  1  no free entry
- issue_valid  out  1  issue packet valid
- issue_opa_value, issue_opb_value  out  `XLEN each  operands
- issue_dest_preg_idx  out  `PRF_LEN
- issue_rob_idx  out  `ROB_LEN
- issue_PC  out  `XLEN
- issue_func  out  ALU_FUNC

Function
REQ-004 Each entry SHALL hold: valid, opa/opb ready, value and tag, dest_preg_idx, rob_idx, PC, func.
REQ-005 rs_alu_full SHALL be combinational: 1 iff all RS_ALU_SIZE entries are valid, based on current state only.
REQ-006 Dispatch with rs_alu_enable=1 and rs_alu_full=0 SHALL write the lowest-index free entry at the clock edge. Dispatch while full SHALL be ignored, with no state change.
REQ-007 Dispatch bypass: an operand with ready=0 SHALL be written ready, with value cdb_broadcast_value, if cdb_broadcast_valid=1 and its preg_idx equals cdb_dest_preg_idx in the same cycle.
REQ-008 Wakeup: each valid entry operand with ready=0 SHALL become ready and capture cdb_broadcast_value at the edge where cdb_broadcast_valid=1 and the tags match. Both operands of one entry MAY wake on the same broadcast.
REQ-009 An entry SHALL be issue-eligible iff valid and both operands are ready in registered state. An entry woken at edge T SHALL be eligible in the cycle after T, never same-cycle.
REQ-010 Select SHALL pick the lowest-index eligible entry.
REQ-011 Issue outputs SHALL be registered: if alu_ready=1 and an eligible entry exists, the outputs SHALL load that entry and issue_valid=1 at the next edge. The entry SHALL be freed at the same edge.
REQ-012 If alu_ready=0 or no entry is eligible, issue_valid SHALL be 0 at the next edge. Entries SHALL be retained.
REQ-013 Issue and dispatch in one cycle: the freed entry SHALL NOT be reused that cycle, because full/free selection uses pre-edge state. Dispatch SHALL take a different free entry.
REQ-014 commit_mis_pred=1 SHALL, at the edge, clear all entry valid bits and issue_valid, and ignore dispatch and wakeup that cycle.
REQ-015 Latency: a dispatch with both operands ready SHALL give issue_valid at the second edge after dispatch, when the ALU is ready and the entry wins selection.

Reset
REQ-016 reset SHALL clear all entry valid bits and set issue_valid=0.
REQ-017 On reset, issue data outputs SHALL be 0, with issue_PC=`XLEN'hfacebeec.
REQ-018 After reset, rs_alu_full SHALL be 0.
REQ-019 reset SHALL take priority over all inputs.

Structure
REQ-020 ALU_FUNC, RS_ALU_PACKET (entry struct), `XLEN, `PRF_LEN, `ROB_LEN and RS_ALU_SIZE/LEN SHALL live in the shared sys_defs package.
REQ-021 Free-entry and issue selection SHALL each use one psel_gen instance (WIDTH=RS_ALU_SIZE, REQS=1), reversed so that the lowest index wins. No other sub-modules.

Verification
REQ-022 Ready dispatch: opa=5, opb=7 both ready, alu_ready=1. Required: issue_valid=1 two edges later with values 5/7; rs_alu_full stays 0.
REQ-023 Wakeup: dispatch with opa tag p12 not ready; CDB p12=0x33 three cycles later. Required: issue one edge after the broadcast edge, with opa=0x33.
REQ-024 Bypass: dispatch opb tag p9 not ready in the same cycle as CDB p9=0xAB. Required: the entry is stored ready and issues the next cycle with opb=0xAB.
REQ-025 Full: 8 dispatches with alu_ready=0. Required: rs_alu_full=1 and a 9th dispatch is dropped. Then alu_ready=1: issues in entry order 0..7, with full dropping to 0 after the first issue.
REQ-026 Flush: 4 valid entries, then commit_mis_pred=1 along with a dispatch and a CDB hit. Required: next cycle all entries invalid, issue_valid=0, no later issues.
REQ-027 Reset mid-operation: reset asserted while issue_valid=1 with 3 entries waiting. Required: next cycle issue_valid=0, issue_PC=facebeec, empty.

Source files
------------

// File: rtl/sys_defs.sv
// Shared system definitions: datapath widths, ALU opcodes and the RS_ALU entry payload.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define XLEN    32
`define PRF_LEN 6
`define ROB_LEN 5
`endif

package sys_defs;

  localparam int unsigned XLEN        = `XLEN;
  localparam int unsigned PRF_LEN     = `PRF_LEN;
  localparam int unsigned ROB_LEN     = `ROB_LEN;
  localparam int unsigned RS_ALU_SIZE = 8;
  localparam int unsigned RS_ALU_LEN  = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } ALU_FUNC;

  typedef struct packed {
    logic                valid;
    logic                opa_ready;
    logic                opb_ready;
    logic [XLEN-1:0]     opa_value;
    logic [XLEN-1:0]     opb_value;
    logic [PRF_LEN-1:0]  opa_preg_idx;
    logic [PRF_LEN-1:0]  opb_preg_idx;
    logic [PRF_LEN-1:0]  dest_preg_idx;
    logic [ROB_LEN-1:0]  rob_idx;
    logic [XLEN-1:0]     PC;
    ALU_FUNC             func;
  } RS_ALU_PACKET;

endpackage

// File: rtl/psel_gen.sv
// Priority selector: grants up to REQS requests, highest index first.
module psel_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REQS  = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             empty
);

  // Walk from the top bit down, granting until REQS grants are issued.
  always_comb begin
    int unsigned cnt;
    gnt   = '0;
    cnt   = 0;
    empty = ~|req;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req[i] && (cnt < REQS)) begin
        gnt[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: dispatch into the lowest free slot, CDB wakeup,
// registered issue of the lowest-index ready entry.
module rs_alu
  import sys_defs::*;
#(
  parameter int unsigned RS_ALU_SIZE = 8,
  parameter int unsigned RS_ALU_LEN  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                commit_mis_pred,
  input  logic                rs_alu_enable,
  input  logic                opa_ready,
  input  logic                opb_ready,
  input  logic [`XLEN-1:0]    opa_value,
  input  logic [`XLEN-1:0]    opb_value,
  input  logic [`PRF_LEN-1:0] opa_preg_idx,
  input  logic [`PRF_LEN-1:0] opb_preg_idx,
  input  logic [`PRF_LEN-1:0] dest_preg_idx,
  input  logic [`ROB_LEN-1:0] rob_idx,
  input  logic [`XLEN-1:0]    PC,
  input  ALU_FUNC             alu_func,
  input  logic                cdb_broadcast_valid,
  input  logic [`PRF_LEN-1:0] cdb_dest_preg_idx,
  input  logic [`XLEN-1:0]    cdb_broadcast_value,
  input  logic                alu_ready,
  output logic                rs_alu_full,
  output logic                issue_valid,
  output logic [`XLEN-1:0]    issue_opa_value,
  output logic [`XLEN-1:0]    issue_opb_value,
  output logic [`PRF_LEN-1:0] issue_dest_preg_idx,
  output logic [`ROB_LEN-1:0] issue_rob_idx,
  output logic [`XLEN-1:0]    issue_PC,
  output ALU_FUNC             issue_func
);

  localparam logic [`XLEN-1:0] RESET_PC = `XLEN'(32'hfacebeec);

  RS_ALU_PACKET entries_q [RS_ALU_SIZE];
  RS_ALU_PACKET entries_d [RS_ALU_SIZE];
  RS_ALU_PACKET disp_pkt;

  logic                issue_valid_q, issue_valid_d;
  logic [`XLEN-1:0]    issue_opa_q, issue_opa_d;
  logic [`XLEN-1:0]    issue_opb_q, issue_opb_d;
  logic [`PRF_LEN-1:0] issue_dest_q, issue_dest_d;
  logic [`ROB_LEN-1:0] issue_rob_q, issue_rob_d;
  logic [`XLEN-1:0]    issue_pc_q, issue_pc_d;
  ALU_FUNC             issue_func_q, issue_func_d;

  logic [RS_ALU_SIZE-1:0] free_vec, free_rev, alloc_rev, alloc_gnt;
  logic [RS_ALU_SIZE-1:0] elig_vec, elig_rev, issue_rev, issue_gnt;
  logic                   no_free, no_elig;
  logic [RS_ALU_LEN-1:0]  alloc_idx, issue_idx;

  // Free and eligible vectors from registered state, bit-reversed so the selector favours index 0.
  always_comb begin
    for (int i = 0; i < int'(RS_ALU_SIZE); i++) begin
      free_vec[i] = ~entries_q[i].valid;
      elig_vec[i] = entries_q[i].valid & entries_q[i].opa_ready & entries_q[i].opb_ready;
    end
    for (int i = 0; i < int'(RS_ALU_SIZE); i++) begin
      free_rev[i]  = free_vec[int'(RS_ALU_SIZE) - 1 - i];
      elig_rev[i]  = elig_vec[int'(RS_ALU_SIZE) - 1 - i];
      alloc_gnt[i] = alloc_rev[int'(RS_ALU_SIZE) - 1 - i];
      issue_gnt[i] = issue_rev[int'(RS_ALU_SIZE) - 1 - i];
    end
  end

  psel_gen #(.WIDTH(RS_ALU_SIZE), .REQS(1)) u_alloc_sel (
    .req   (free_rev),
    .gnt   (alloc_rev),
    .empty (no_free)
  );

  psel_gen #(.WIDTH(RS_ALU_SIZE), .REQS(1)) u_issue_sel (
    .req   (elig_rev),
    .gnt   (issue_rev),
    .empty (no_elig)
  );

  assign rs_alu_full = no_free;

  // One-hot grants to indices.
  always_comb begin
    alloc_idx = '0;
    issue_idx = '0;
    for (int i = 0; i < int'(RS_ALU_SIZE); i++) begin
      if (alloc_gnt[i]) alloc_idx = RS_ALU_LEN'(i);
      if (issue_gnt[i]) issue_idx = RS_ALU_LEN'(i);
    end
  end

  // Incoming dispatch packet, with same-cycle CDB bypass into not-ready operands.
  always_comb begin
    disp_pkt               = '0;
    disp_pkt.valid         = 1'b1;
    disp_pkt.opa_ready     = opa_ready;
    disp_pkt.opb_ready     = opb_ready;
    disp_pkt.opa_value     = opa_value;
    disp_pkt.opb_value     = opb_value;
    disp_pkt.opa_preg_idx  = opa_preg_idx;
    disp_pkt.opb_preg_idx  = opb_preg_idx;
    disp_pkt.dest_preg_idx = dest_preg_idx;
    disp_pkt.rob_idx       = rob_idx;
    disp_pkt.PC            = PC;
    disp_pkt.func          = alu_func;
    if (cdb_broadcast_valid && !opa_ready && (opa_preg_idx == cdb_dest_preg_idx)) begin
      disp_pkt.opa_ready = 1'b1;
      disp_pkt.opa_value = cdb_broadcast_value;
    end
    if (cdb_broadcast_valid && !opb_ready && (opb_preg_idx == cdb_dest_preg_idx)) begin
      disp_pkt.opb_ready = 1'b1;
      disp_pkt.opb_value = cdb_broadcast_value;
    end
  end

  // Next state: flush, else wakeup, issue and dispatch against pre-edge selection.
  always_comb begin
    entries_d     = entries_q;
    issue_valid_d = 1'b0;
    issue_opa_d   = issue_opa_q;
    issue_opb_d   = issue_opb_q;
    issue_dest_d  = issue_dest_q;
    issue_rob_d   = issue_rob_q;
    issue_pc_d    = issue_pc_q;
    issue_func_d  = issue_func_q;
    if (commit_mis_pred) begin
      for (int i = 0; i < int'(RS_ALU_SIZE); i++) entries_d[i].valid = 1'b0;
    end else begin
      for (int i = 0; i < int'(RS_ALU_SIZE); i++) begin
        if (entries_q[i].valid && cdb_broadcast_valid) begin
          if (!entries_q[i].opa_ready && (entries_q[i].opa_preg_idx == cdb_dest_preg_idx)) begin
            entries_d[i].opa_ready = 1'b1;
            entries_d[i].opa_value = cdb_broadcast_value;
          end
          if (!entries_q[i].opb_ready && (entries_q[i].opb_preg_idx == cdb_dest_preg_idx)) begin
            entries_d[i].opb_ready = 1'b1;
            entries_d[i].opb_value = cdb_broadcast_value;
          end
        end
      end
      if (alu_ready && !no_elig) begin
        issue_valid_d                = 1'b1;
        issue_opa_d                  = entries_q[issue_idx].opa_value;
        issue_opb_d                  = entries_q[issue_idx].opb_value;
        issue_dest_d                 = entries_q[issue_idx].dest_preg_idx;
        issue_rob_d                  = entries_q[issue_idx].rob_idx;
        issue_pc_d                   = entries_q[issue_idx].PC;
        issue_func_d                 = entries_q[issue_idx].func;
        entries_d[issue_idx].valid   = 1'b0;
      end
      if (rs_alu_enable && !no_free) entries_d[alloc_idx] = disp_pkt;
    end
  end

  // State and issue registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(RS_ALU_SIZE); i++) entries_q[i] <= '0;
      issue_valid_q <= 1'b0;
      issue_opa_q   <= '0;
      issue_opb_q   <= '0;
      issue_dest_q  <= '0;
      issue_rob_q   <= '0;
      issue_pc_q    <= RESET_PC;
      issue_func_q  <= ALU_ADD;
    end else begin
      entries_q     <= entries_d;
      issue_valid_q <= issue_valid_d;
      issue_opa_q   <= issue_opa_d;
      issue_opb_q   <= issue_opb_d;
      issue_dest_q  <= issue_dest_d;
      issue_rob_q   <= issue_rob_d;
      issue_pc_q    <= issue_pc_d;
      issue_func_q  <= issue_func_d;
    end
  end

  assign issue_valid         = issue_valid_q;
  assign issue_opa_value     = issue_opa_q;
  assign issue_opb_value     = issue_opb_q;
  assign issue_dest_preg_idx = issue_dest_q;
  assign issue_rob_idx       = issue_rob_q;
  assign issue_PC            = issue_pc_q;
  assign issue_func          = issue_func_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed, table-driven bench for rs_alu.
module tb_rs_alu;
  import sys_defs::*;

  localparam int unsigned XW = XLEN;
  localparam int unsigned PW = PRF_LEN;
  localparam int unsigned RW = ROB_LEN;

  logic          clock = 1'b0;
  logic          reset;
  logic          commit_mis_pred;
  logic          rs_alu_enable;
  logic          opa_ready, opb_ready;
  logic [XW-1:0] opa_value, opb_value;
  logic [PW-1:0] opa_preg_idx, opb_preg_idx, dest_preg_idx;
  logic [RW-1:0] rob_idx;
  logic [XW-1:0] PC;
  ALU_FUNC       alu_func;
  logic          cdb_broadcast_valid;
  logic [PW-1:0] cdb_dest_preg_idx;
  logic [XW-1:0] cdb_broadcast_value;
  logic          alu_ready;
  logic          rs_alu_full;
  logic          issue_valid;
  logic [XW-1:0] issue_opa_value, issue_opb_value, issue_PC;
  logic [PW-1:0] issue_dest_preg_idx;
  logic [RW-1:0] issue_rob_idx;
  ALU_FUNC       issue_func;

  int checks   = 0;
  int failures = 0;

  rs_alu #(.RS_ALU_SIZE(8), .RS_ALU_LEN(3)) dut (
    .clock               (clock),
    .reset               (reset),
    .commit_mis_pred     (commit_mis_pred),
    .rs_alu_enable       (rs_alu_enable),
    .opa_ready           (opa_ready),
    .opb_ready           (opb_ready),
    .opa_value           (opa_value),
    .opb_value           (opb_value),
    .opa_preg_idx        (opa_preg_idx),
    .opb_preg_idx        (opb_preg_idx),
    .dest_preg_idx       (dest_preg_idx),
    .rob_idx             (rob_idx),
    .PC                  (PC),
    .alu_func            (alu_func),
    .cdb_broadcast_valid (cdb_broadcast_valid),
    .cdb_dest_preg_idx   (cdb_dest_preg_idx),
    .cdb_broadcast_value (cdb_broadcast_value),
    .alu_ready           (alu_ready),
    .rs_alu_full         (rs_alu_full),
    .issue_valid         (issue_valid),
    .issue_opa_value     (issue_opa_value),
    .issue_opb_value     (issue_opb_value),
    .issue_dest_preg_idx (issue_dest_preg_idx),
    .issue_rob_idx       (issue_rob_idx),
    .issue_PC            (issue_PC),
    .issue_func          (issue_func)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic          oar;
    logic [XW-1:0] oav;
    logic [PW-1:0] oat;
    logic          obr;
    logic [XW-1:0] obv;
    logic [PW-1:0] obt;
    logic [RW-1:0] rob;
    logic          cv;
    logic [PW-1:0] ct;
    logic [XW-1:0] cval;
    logic          ar;
    logic          e_iv;
    logic [XW-1:0] e_a;
    logic [XW-1:0] e_b;
    logic [RW-1:0] e_rob;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic oar, input int oav, input int oat,
                              input logic obr, input int obv, input int obt, input int rob,
                              input logic cv, input int ct, input int cval, input logic ar,
                              input logic e_iv, input int e_a, input int e_b, input int e_rob);
    vec_t v;
    v.en = en; v.oar = oar; v.oav = XW'(oav); v.oat = PW'(oat);
    v.obr = obr; v.obv = XW'(obv); v.obt = PW'(obt); v.rob = RW'(rob);
    v.cv = cv; v.ct = PW'(ct); v.cval = XW'(cval); v.ar = ar;
    v.e_iv = e_iv; v.e_a = XW'(e_a); v.e_b = XW'(e_b); v.e_rob = RW'(e_rob);
    return v;
  endfunction

  function automatic logic [PW-1:0] dest_of(input logic [RW-1:0] r);
    return PW'(r) + PW'(1);
  endfunction

  function automatic logic [XW-1:0] pc_of(input logic [RW-1:0] r);
    return XW'(32'h1000) + XW'(r) * XW'(4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs_alu_enable = 1'b0; commit_mis_pred = 1'b0;
    opa_ready = 1'b0; opb_ready = 1'b0; opa_value = '0; opb_value = '0;
    opa_preg_idx = '0; opb_preg_idx = '0; dest_preg_idx = '0; rob_idx = '0; PC = '0;
    alu_func = ALU_ADD; cdb_broadcast_valid = 1'b0; cdb_dest_preg_idx = '0;
    cdb_broadcast_value = '0; alu_ready = 1'b0;
  endtask

  task automatic disp(input logic oar, input int oav, input int oat,
                      input logic obr, input int obv, input int obt, input int rob);
    rs_alu_enable = 1'b1;
    opa_ready = oar; opa_value = XW'(oav); opa_preg_idx = PW'(oat);
    opb_ready = obr; opb_value = XW'(obv); opb_preg_idx = PW'(obt);
    rob_idx = RW'(rob); dest_preg_idx = dest_of(RW'(rob)); PC = pc_of(RW'(rob));
    alu_func = ALU_XOR;
  endtask

  task automatic cdb(input int tag, input int val);
    cdb_broadcast_valid = 1'b1; cdb_dest_preg_idx = PW'(tag); cdb_broadcast_value = XW'(val);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_issue_pc", 64'(issue_PC), 64'hfacebeec);
    chk("reset_issue_opa", 64'(issue_opa_value), 64'd0);
    chk("reset_issue_dest", 64'(issue_dest_preg_idx), 64'd0);
    chk("reset_full", 64'(rs_alu_full), 64'd0);
    reset = 1'b0;

    //           en  oar oav   oat obr obv   obt rob cv  ct  cval  ar  e_iv e_a   e_b   e_rob
    vecs.push_back(mk(1, 1, 5,    0,  1,  7,    0,  1,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   5,    7,    1));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(1, 0, 0,    12, 1,  3,    0,  2,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  1,  12, 'h33, 1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   'h33, 3,    2));
    vecs.push_back(mk(1, 1, 1,    0,  0,  0,    9,  3,  1,  9,  'hAB, 1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   1,    'hAB, 3));
    vecs.push_back(mk(1, 0, 0,    4,  1,  2,    0,  4,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  1,  5,  'h55, 1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  1,  4,  'h44, 1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   'h44, 2,    4));
    vecs.push_back(mk(1, 0, 0,    7,  0,  0,    7,  5,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  1,  7,  'h77, 1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   'h77, 'h77, 5));
    vecs.push_back(mk(1, 1, 10,   0,  1,  11,   0,  6,  0,  0,  0,    0,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    0,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   10,   11,   6));
    vecs.push_back(mk(1, 0, 0,    20, 1,  1,    0,  7,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(1, 1, 8,    0,  1,  9,    0,  8,  0,  0,  0,    1,  0,   0,    0,    0));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  1,  20, 'h20, 1,  1,   8,    9,    8));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  1,   'h20, 1,    7));
    vecs.push_back(mk(0, 0, 0,    0,  0,  0,    0,  0,  0,  0,  0,    1,  0,   0,    0,    0));

    foreach (vecs[k]) begin
      idle();
      if (vecs[k].en) disp(vecs[k].oar, int'(vecs[k].oav), int'(vecs[k].oat),
                           vecs[k].obr, int'(vecs[k].obv), int'(vecs[k].obt), int'(vecs[k].rob));
      if (vecs[k].cv) cdb(int'(vecs[k].ct), int'(vecs[k].cval));
      alu_ready = vecs[k].ar;
      step();
      chk($sformatf("row%0d_issue_valid", k), 64'(issue_valid), 64'(vecs[k].e_iv));
      chk($sformatf("row%0d_full", k), 64'(rs_alu_full), 64'd0);
      if (vecs[k].e_iv) begin
        chk($sformatf("row%0d_opa", k), 64'(issue_opa_value), 64'(vecs[k].e_a));
        chk($sformatf("row%0d_opb", k), 64'(issue_opb_value), 64'(vecs[k].e_b));
        chk($sformatf("row%0d_rob", k), 64'(issue_rob_idx), 64'(vecs[k].e_rob));
        chk($sformatf("row%0d_dest", k), 64'(issue_dest_preg_idx), 64'(dest_of(vecs[k].e_rob)));
        chk($sformatf("row%0d_pc", k), 64'(issue_PC), 64'(pc_of(vecs[k].e_rob)));
        chk($sformatf("row%0d_func", k), 64'(issue_func), 64'(ALU_XOR));
      end
    end

    // Fill all eight entries with the ALU stalled, then drop a ninth dispatch.
    for (int i = 0; i < 8; i++) begin
      idle();
      disp(1'b1, 'h100 + i, 0, 1'b1, 'h200 + i, 0, i);
      step();
      chk($sformatf("fill%0d_full", i), 64'(rs_alu_full), (i == 7) ? 64'd1 : 64'd0);
      chk($sformatf("fill%0d_issue_valid", i), 64'(issue_valid), 64'd0);
    end
    idle();
    disp(1'b1, 'h999, 0, 1'b1, 'h999, 0, 9);
    step();
    chk("ninth_full", 64'(rs_alu_full), 64'd1);
    chk("ninth_issue_valid", 64'(issue_valid), 64'd0);
    idle();
    alu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d_valid", i), 64'(issue_valid), 64'd1);
      chk($sformatf("drain%0d_rob", i), 64'(issue_rob_idx), 64'(i));
      chk($sformatf("drain%0d_opa", i), 64'(issue_opa_value), 64'('h100 + i));
      chk($sformatf("drain%0d_full", i), 64'(rs_alu_full), 64'd0);
    end
    step();
    chk("drain_done_valid", 64'(issue_valid), 64'd0);

    // Flush with three waiting entries plus one eligible, alongside dispatch and CDB hit.
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_ready = 1'b1;
      disp(1'b0, 0, 30, 1'b1, i, 0, 10 + i);
      step();
    end
    idle();
    alu_ready = 1'b1;
    disp(1'b1, 'h14, 0, 1'b1, 'h15, 0, 14);
    step();
    idle();
    alu_ready = 1'b1;
    commit_mis_pred = 1'b1;
    disp(1'b1, 1, 0, 1'b1, 2, 0, 15);
    cdb(30, 'h30);
    step();
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    chk("flush_full", 64'(rs_alu_full), 64'd0);
    idle();
    alu_ready = 1'b1;
    cdb(30, 'h31);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_flush%0d_valid", i), 64'(issue_valid), 64'd0);
      idle();
      alu_ready = 1'b1;
    end

    // Reset while an issue is on the outputs and three entries still wait.
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_ready = 1'b1;
      disp(1'b1, 0, 0, 1'b0, 0, 40, 20 + i);
      step();
    end
    idle();
    alu_ready = 1'b1;
    disp(1'b1, 'h66, 0, 1'b1, 'h67, 0, 23);
    step();
    idle();
    alu_ready = 1'b1;
    step();
    chk("pre_reset_valid", 64'(issue_valid), 64'd1);
    chk("pre_reset_rob", 64'(issue_rob_idx), 64'd23);
    reset = 1'b1;
    disp(1'b1, 1, 0, 1'b1, 1, 0, 24);
    cdb(40, 'h40);
    step();
    chk("mid_reset_valid", 64'(issue_valid), 64'd0);
    chk("mid_reset_pc", 64'(issue_PC), 64'hfacebeec);
    chk("mid_reset_opa", 64'(issue_opa_value), 64'd0);
    chk("mid_reset_full", 64'(rs_alu_full), 64'd0);
    reset = 1'b0;
    idle();
    alu_ready = 1'b1;
    cdb(40, 'h41);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_reset%0d_valid", i), 64'(issue_valid), 64'd0);
      idle();
      alu_ready = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
